// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory access stage with byte-lane masking and load extension
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned halfword/word instead of aligning)
module load_store_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata_out,
  output logic                  rdata_valid,
  output logic                  stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [3:0]            dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  misalign_fault
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t                r_state, w_next;
  logic [1:0]            r_off;
  logic [2:0]            r_funct3;
  logic                  r_we;
  logic [3:0]            r_be;
  logic [DATA_WIDTH-1:0] r_addr, r_wdata, r_rdata;
  logic                  r_rvalid, r_misalign;

  logic                  w_accept, w_misalign;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata, w_load;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdata;
    case (funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {addr[1], 1'b0};
        w_wdata = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = (funct3[1:0] == 2'b01) ? addr[0] :
                      (funct3[1] ? (addr[1:0] != 2'b00) : 1'b0);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) && req_valid;

  // Lane selection uses the offset captured at accept, not the live address.
  always_comb begin
    w_byte = dmem_rdata[{r_off, 3'b000} +: 8];
    w_half = dmem_rdata[{r_off[1], 4'b0000} +: 16];
    case (r_funct3)
      3'b000:  w_load = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      3'b100:  w_load = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      3'b001:  w_load = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      3'b101:  w_load = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: w_load = dmem_rdata;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    stall     = 1'b0;
    dmem_req  = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !w_misalign) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        stall    = 1'b1;
        dmem_req = 1'b1;
        if (dmem_ack) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_off      <= '0;
      r_funct3   <= '0;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_rvalid   <= 1'b0;
      r_misalign <= w_accept && w_misalign;
      if (w_accept && !w_misalign) begin
        r_off    <= addr[1:0];
        r_funct3 <= funct3;
        r_we     <= mem_write;
        r_be     <= w_be;
        r_addr   <= {addr[DATA_WIDTH-1:2], 2'b00};
        r_wdata  <= w_wdata;
      end
      if (r_state == S_ACCESS && dmem_ack && !r_we) begin
        r_rdata  <= w_load;
        r_rvalid <= 1'b1;
      end
    end
  end

  assign rdata_out      = r_rdata;
  assign rdata_valid    = r_rvalid;
  assign dmem_we        = r_we;
  assign dmem_be        = r_be;
  assign dmem_addr      = r_addr;
  assign dmem_wdata     = r_wdata;
  assign misalign_fault = r_misalign;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed scoreboard bench for load_store_unit
module tb_load_store_unit;

  logic        clk, rst, req_valid, req_ready, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata_out, dmem_addr, dmem_wdata, dmem_rdata;
  logic        rdata_valid, stall, dmem_req, dmem_we, dmem_ack, misalign_fault;
  logic [3:0]  dmem_be;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .mem_write(mem_write), .funct3(funct3), .addr(addr), .wdata(wdata),
    .rdata_out(rdata_out), .rdata_valid(rdata_valid), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .misalign_fault(misalign_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rdata_valid === 1'b1) begin
      if (sb.size() == 0) check("unexpected_rdata_valid", 32'd1, 32'd0);
      else check("rdata_out", rdata_out, sb.pop_front());
    end
  end

  // One complete transaction: accept, ack after ack_delay cycles, return to IDLE.
  task automatic do_access(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int ack_delay,
                           input logic [3:0] exp_be, input logic [31:0] exp_addr,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_load);
    @(posedge clk); #1;
    req_valid = 1'b1; mem_write = we; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    check({tag, "_ready_idle"}, req_ready, 1'b1);
    @(posedge clk); #1;
    if (!we) sb.push_back(exp_load);
    req_valid = 1'b0; addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
    for (int d = 0; d <= ack_delay; d++) begin
      if (d == ack_delay) begin
        dmem_ack = 1'b1; dmem_rdata = rd;
      end
      @(negedge clk);
      check({tag, "_req"},   dmem_req, 1'b1);
      check({tag, "_stall"}, stall, 1'b1);
      check({tag, "_ready"}, req_ready, 1'b0);
      check({tag, "_we"},    dmem_we, we);
      check({tag, "_be"},    dmem_be, exp_be);
      check({tag, "_addr"},  dmem_addr, exp_addr);
      check({tag, "_wdata"}, dmem_wdata, exp_wdata);
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0; dmem_rdata = $urandom;
    @(negedge clk);
    check({tag, "_ready_back"}, req_ready, 1'b1);
    check({tag, "_req_drop"},   dmem_req, 1'b0);
    check({tag, "_rvalid"},     rdata_valid, !we);
    @(negedge clk);
    check({tag, "_rvalid_pulse"}, rdata_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    addr = '0; wdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    #2;
    check("rst_ready",  req_ready, 1'b1);
    check("rst_stall",  stall, 1'b0);
    check("rst_req",    dmem_req, 1'b0);
    check("rst_rvalid", rdata_valid, 1'b0);
    check("rst_rdata",  rdata_out, 32'h0);
    check("rst_be",     dmem_be, 4'h0);
    check("rst_fault",  misalign_fault, 1'b0);
    @(posedge clk); #1; rst = 1'b0;

    do_access("sw",  1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 4'b1111, 32'h100, 32'hDEADBEEF, 32'h0);
    do_access("sb",  1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1, 4'b1000, 32'h100, 32'hA5A5A5A5, 32'h0);
    do_access("lb",  1'b0, 3'b000, 32'h102, 32'h0, 32'h12F03456, 0, 4'b0100, 32'h100, 32'h0, 32'hFFFFFFF0);
    do_access("lbu", 1'b0, 3'b100, 32'h102, 32'h0, 32'h12F03456, 0, 4'b0100, 32'h100, 32'h0, 32'h000000F0);
    do_access("lh",  1'b0, 3'b001, 32'h102, 32'h0, 32'h80017FFF, 3, 4'b1100, 32'h100, 32'h0, 32'hFFFF8001);
    do_access("lhu", 1'b0, 3'b101, 32'h100, 32'h0, 32'h80017FFF, 0, 4'b0011, 32'h100, 32'h0, 32'h00007FFF);
    do_access("lw",  1'b0, 3'b010, 32'h104, 32'h0, 32'h11223344, 2, 4'b1111, 32'h104, 32'h0, 32'h11223344);
    do_access("sh",  1'b1, 3'b001, 32'h102, 32'hCAFE1234, 32'h0, 0, 4'b1100, 32'h100, 32'h12341234, 32'h0);
    check("rdata_hold", rdata_out, 32'h11223344);

    // Reset while the request is outstanding; a late ack must be ignored.
    @(posedge clk); #1;
    req_valid = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h200;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rstmid_req_before", dmem_req, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("rstmid_req_drop", dmem_req, 1'b0);
    check("rstmid_ready",    req_ready, 1'b1);
    check("rstmid_stall",    stall, 1'b0);
    check("rstmid_rdata",    rdata_out, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h55AA55AA;
    @(negedge clk);
    check("late_ack_req", dmem_req, 1'b0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_rvalid", rdata_valid, 1'b0);
    check("late_ack_ready",  req_ready, 1'b1);

`ifdef MISALIGN_TRAP_EN
    @(posedge clk); #1;
    req_valid = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h101;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("mis_req",    dmem_req, 1'b0);
    check("mis_fault",  misalign_fault, 1'b1);
    check("mis_ready",  req_ready, 1'b1);
    check("mis_rvalid", rdata_valid, 1'b0);
    @(negedge clk);
    check("mis_fault_pulse", misalign_fault, 1'b0);
    check("mis_rdata_hold",  rdata_out, 32'h0);
`else
    do_access("lw_mis", 1'b0, 3'b010, 32'h101, 32'h0, 32'hA1B2C3D4, 0, 4'b1111, 32'h100, 32'h0, 32'hA1B2C3D4);
    check("mis_fault_tied", misalign_fault, 1'b0);
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Data-memory access stage that consumes the execute stage's ALU_out as the effective address and r_out2 as store data.
- Issues one byte-lane-masked request per instruction to the data memory through a req/ack handshake.
- Returns sign- or zero-extended load data to writeback.
- Asserts stall while a transaction is outstanding so the pipeline front end holds.

Parameters:
DATA_WIDTH, 32, width of address, data, and the returned load value (unit supports 32 only; 4 byte lanes).

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  execute stage presents a memory instruction
req_ready  output  1  unit can accept a request (state IDLE)
mem_write  input  1  1 = store, 0 = load
funct3  input  3  RISC-V funct3 of the load/store
addr  input  DATA_WIDTH  effective address (ALU_out)
wdata  input  DATA_WIDTH  store data (r_out2)
rdata_out  output  DATA_WIDTH  extended load result
rdata_valid  output  1  one-cycle pulse, rdata_out valid
stall  output  1  transaction in flight
dmem_req  output  1  memory request, held until dmem_ack
dmem_we  output  1  request is a write
dmem_be  output  4  byte enables, bit i = byte lane i
dmem_addr  output  DATA_WIDTH  word-aligned address {addr[31:2],2'b00}
dmem_wdata  output  DATA_WIDTH  lane-replicated store data
dmem_ack  input  1  memory completes request (read data valid this cycle)
dmem_rdata  input  DATA_WIDTH  full read word
misalign_fault  output  1  misaligned access pulse (tied 0 without feature)

Behaviour:
- Reset: state IDLE; every registered output is 0.
  - dmem_req drops asynchronously; an in-flight transaction is abandoned.
  - req_ready = 1 and stall = 0 because both are decoded from state.
- State IDLE:
  - req_ready = 1, stall = 0.
  - On req_valid, register addr[1:0], funct3, mem_write, dmem_addr, dmem_be and dmem_wdata, then go to ACCESS.
- State ACCESS:
  - dmem_req = 1, stall = 1, req_ready = 0; request fields are held stable.
  - On dmem_ack, go to IDLE the next cycle.
  - On a load ack, register the extracted load into rdata_out and pulse rdata_valid for one cycle (the cycle after ack).
  - On a store ack, rdata_valid stays 0.
- rdata_out holds its value until the next load completes.
- Minimum latency: accept at edge N, dmem_req high in cycle N+1. A same-cycle ack gives rdata_valid in cycle N+2 and req_ready high again in cycle N+2.
- Size decode:
  - 000 / 100: byte; dmem_be = 4'b0001 << addr[1:0].
  - 001 / 101: halfword; dmem_be = 4'b0011 << {addr[1],1'b0}.
  - 010 and unused codes 011 / 110 / 111: word; dmem_be = 4'b1111.
- Store data:
  - byte: {4{wdata[7:0]}}
  - halfword: {2{wdata[15:0]}}
  - word: wdata
- Load extract uses the registered lane from dmem_rdata:
  - 000 LB: sign-extend byte.
  - 100 LBU: zero-extend byte.
  - 001 LH: sign-extend halfword.
  - 101 LHU: zero-extend halfword.
  - other codes: full word.
- Without the optional feature, ignored low bits: addr[0] for halfword, addr[1:0] for word.
- dmem_ack while IDLE is ignored. dmem_rdata is sampled only on the ack cycle. req_valid while ACCESS is ignored, since the requester must hold until req_ready.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a halfword with addr[0] = 1, or a word with addr[1:0] != 0, accepted in IDLE issues no dmem transaction.
  - misalign_fault pulses for one cycle after accept.
  - rdata_valid stays 0 and rdata_out is unchanged.
  - State returns to IDLE, so req_ready is high again the next cycle.
- Undefined: misalign_fault is tied to 0 and the access aligns as described in Behaviour.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, ack same cycle as req -> dmem_addr=0x100, be=1111, we=1, dmem_wdata=0xDEADBEEF; req_ready low exactly 1 cycle; rdata_valid never asserts.
- SB addr=0x103, wdata=0x000000A5 -> be=1000, dmem_wdata=0xA5A5A5A5, dmem_addr=0x100.
- LB / LBU addr=0x102, dmem_rdata=0x12F03456 -> LB rdata_out=0xFFFFFFF0; LBU rdata_out=0x000000F0; rdata_valid 1-cycle pulse each.
- LH addr=0x102, dmem_rdata=0x80017FFF, ack delayed 3 cycles -> dmem_req and stall high 4 cycles with stable fields; rdata_out=0xFFFF8001.
- Assert rst while in ACCESS before ack, then ack after release -> dmem_req low immediately; late ack ignored; no rdata_valid; req_ready=1.
- With MISALIGN_TRAP_EN, LW addr=0x101 -> no dmem_req; misalign_fault pulse; rdata_valid=0. Without the macro -> dmem_addr=0x100, be=1111.
